// File: rtl/rr_bus_master_mux_if.sv
// Bundle between the master mux, its masters, the round-robin arbiter and the shared slave.
// The mux uses the master modport; the surrounding environment uses the slave modport.
interface rr_bus_master_mux_if #(
    parameter int USER      = 4,
    parameter int USER_LOG2 = (USER > 1) ? $clog2(USER) : 1,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
);
    logic [USER-1:0]        m_req;
    logic [USER-1:0]        m_we;
    logic [USER*ADDR_W-1:0] m_addr;
    logic [USER*DATA_W-1:0] m_wdata;
    logic [USER-1:0]        m_ack;
    logic [USER-1:0]        m_rvalid;
    logic [DATA_W-1:0]      m_rdata;
    logic                   m_rerr;
    logic [USER-1:0]        arb_request;
    logic [USER-1:0]        arb_grant;
    logic [USER_LOG2-1:0]   arb_grant_user;
    logic                   s_req;
    logic                   s_we;
    logic [ADDR_W-1:0]      s_addr;
    logic [DATA_W-1:0]      s_wdata;
    logic                   s_ready;
    logic                   s_rvalid;
    logic [DATA_W-1:0]      s_rdata;

    modport master (
        input  m_req, m_we, m_addr, m_wdata, arb_grant, arb_grant_user,
               s_ready, s_rvalid, s_rdata,
        output m_ack, m_rvalid, m_rdata, m_rerr, arb_request,
               s_req, s_we, s_addr, s_wdata
    );

    modport slave (
        output m_req, m_we, m_addr, m_wdata, arb_grant, arb_grant_user,
               s_ready, s_rvalid, s_rdata,
        input  m_ack, m_rvalid, m_rdata, m_rerr, arb_request,
               s_req, s_we, s_addr, s_wdata
    );
endinterface

// File: rtl/rr_bus_master_mux.sv
// Multi-master front end for one shared slave: locks the arbiter winner for a whole
// transaction, muxes its command out and returns the response (one outstanding, watchdog).
module rr_bus_master_mux #(
    parameter int USER      = 4,
    parameter int USER_LOG2 = (USER > 1) ? $clog2(USER) : 1,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT   = 255
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    rr_bus_master_mux_if.master  bus
);
    localparam int WDOG_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WDOG_W-1:0] WDOG_LAST = (TIMEOUT > 0) ? WDOG_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                state_q, state_d;
    logic [USER_LOG2-1:0]  owner_q, owner_d;
    logic                  we_q, we_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic                  rerr_q, rerr_d;
    logic [WDOG_W-1:0]     wdog_q, wdog_d;
    logic [USER-1:0]       owner_oh;
    logic [31:0]           gidx;

    assign bus.s_we    = we_q;
    assign bus.s_addr  = addr_q;
    assign bus.s_wdata = wdata_q;

    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        we_d            = we_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        rdata_d         = rdata_q;
        rerr_d          = rerr_q;
        wdog_d          = wdog_q;
        gidx            = 32'(bus.arb_grant_user);
        owner_oh        = '0;
        owner_oh[owner_q] = 1'b1;
        // Holding only the owner's bit keeps the arbiter parked on it until we are done.
        bus.arb_request = owner_oh;
        bus.s_req       = 1'b0;
        bus.m_ack       = '0;
        bus.m_rvalid    = '0;
        bus.m_rdata     = '0;
        bus.m_rerr      = 1'b0;

        case (state_q)
            IDLE: begin
                bus.arb_request = bus.m_req;
                if (|bus.arb_grant) begin
                    owner_d = bus.arb_grant_user;
                    we_d    = bus.m_we[gidx];
                    addr_d  = bus.m_addr[gidx*ADDR_W +: ADDR_W];
                    wdata_d = bus.m_wdata[gidx*DATA_W +: DATA_W];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                bus.s_req = 1'b1;
                if (bus.s_ready) begin
                    bus.m_ack = owner_oh;
                    if (bus.s_rvalid) begin
                        rdata_d = bus.s_rdata;
                        rerr_d  = 1'b0;
                        state_d = RESP;
                    end else begin
                        wdog_d  = '0;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (bus.s_rvalid) begin
                    rdata_d = bus.s_rdata;
                    rerr_d  = 1'b0;
                    state_d = RESP;
                end else if (TIMEOUT != 0 && wdog_q == WDOG_LAST) begin
                    rdata_d = '0;
                    rerr_d  = 1'b1;
                    state_d = RESP;
                end else if (TIMEOUT != 0) begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            RESP: begin
                bus.m_rvalid = owner_oh;
                bus.m_rdata  = rdata_q;
                bus.m_rerr   = rerr_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= IDLE;
            owner_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            rerr_q  <= 1'b0;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            rerr_q  <= rerr_d;
            wdog_q  <= wdog_d;
        end
    end
endmodule
